// File: rtl/mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port RAM among instruction fetch (0),
//            load/store unit (1) and debug/program loader (2). One
//            transaction at a time, round-robin grant, registered RAM
//            address/data/strobe, per-requester ack pulse and read data.
// Revision : 1.0 - initial release
// =============================================================================
module mem_port_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = 1     // legal range 1..4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [2:0]        we,
    input  logic [3*AW-1:0]   addr,
    input  logic [3*DW-1:0]   wdata,
    output logic [2:0]        ack,
    output logic [DW-1:0]     rdata,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_write,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WAIT = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    // Wait counter target; three bits comfortably hold the 1..4 range.
    localparam logic [2:0] c_rd_lat = 3'(RD_LAT);

    state_t          r_state;
    state_t          w_next_state;

    logic [1:0]      r_owner;
    logic [1:0]      r_last_owner;
    logic [1:0]      w_grant;
    logic            w_any_req;

    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_sel_we;

    logic [2:0]      r_wait_cnt;
    logic            w_rd_done;
    logic [2:0]      w_owner_onehot;

    logic [2:0]      r_ack;
    logic [DW-1:0]   r_rdata;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_mem_write;

    assign w_any_req      = |req;
    assign w_owner_onehot = 3'b001 << r_owner;
    // The read data is in the RAM output register once the counter reaches
    // the configured latency; that cycle is the capture cycle.
    assign w_rd_done      = (r_state == S_WAIT) && (r_wait_cnt == c_rd_lat);

    // Round-robin pick: search upward starting just after the previous owner.
    always_comb begin
        w_grant = 2'd0;
        case (r_last_owner)
            2'd0: begin
                if (req[1])      w_grant = 2'd1;
                else if (req[2]) w_grant = 2'd2;
                else             w_grant = 2'd0;
            end
            2'd1: begin
                if (req[2])      w_grant = 2'd2;
                else if (req[0]) w_grant = 2'd0;
                else             w_grant = 2'd1;
            end
            default: begin
                if (req[0])      w_grant = 2'd0;
                else if (req[1]) w_grant = 2'd1;
                else             w_grant = 2'd2;
            end
        endcase
    end

    // Route the chosen requester's address, data and direction to the RAM port.
    always_comb begin
        w_sel_addr  = addr[0 +: AW];
        w_sel_wdata = wdata[0 +: DW];
        w_sel_we    = we[0];
        case (w_grant)
            2'd1: begin
                w_sel_addr  = addr[AW +: AW];
                w_sel_wdata = wdata[DW +: DW];
                w_sel_we    = we[1];
            end
            2'd2: begin
                w_sel_addr  = addr[2*AW +: AW];
                w_sel_wdata = wdata[2*DW +: DW];
                w_sel_we    = we[2];
            end
            default: begin
                w_sel_addr  = addr[0 +: AW];
                w_sel_wdata = wdata[0 +: DW];
                w_sel_we    = we[0];
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Reads always pass through WAIT so that the capture
    // edge lands RD_LAT cycles after the address reached the RAM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_XFER;
                end
            end
            S_XFER: begin
                // mem_write still holds the latched direction during XFER.
                w_next_state = r_mem_write ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                if (w_rd_done) begin
                    w_next_state = S_ACK;
                end
            end
            S_ACK: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Grant bookkeeping: owner of the transaction and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner      <= 2'd0;
            r_last_owner <= 2'd2;
        end else if ((r_state == S_IDLE) && w_any_req) begin
            r_owner      <= w_grant;
            r_last_owner <= w_grant;
        end
    end

    // RAM port registers: loaded at the grant edge, strobe cleared after XFER.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_write <= 1'b0;
        end else if ((r_state == S_IDLE) && w_any_req) begin
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_write <= w_sel_we;
        end else begin
            r_mem_write <= 1'b0;
        end
    end

    // Read latency counter: starts at 1 leaving XFER, counts up in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 3'd0;
        end else begin
            case (r_state)
                S_XFER: begin
                    if (!r_mem_write) begin
                        r_wait_cnt <= 3'd1;
                    end
                end
                S_WAIT: begin
                    if (w_rd_done) begin
                        r_wait_cnt <= 3'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end
                end
                default: begin
                    r_wait_cnt <= 3'd0;
                end
            endcase
        end
    end

    // Read data capture; rdata keeps the last read value across writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_rd_done) begin
            r_rdata <= mem_rdata;
        end
    end

    // Acknowledge pulse: registered, high only during the ACK state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack <= 3'b000;
        end else if (w_next_state == S_ACK && r_state != S_ACK) begin
            r_ack <= w_owner_onehot;
        end else begin
            r_ack <= 3'b000;
        end
    end

    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_write = r_mem_write;
    assign busy      = (r_state != S_IDLE);

    // Structural invariants: a single owner per completion, and the write
    // strobe can only be seen while the address is on the RAM.
    a_ack_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(r_ack));
    a_write_in_xfer: assert property (@(posedge clk) disable iff (reset)
        r_mem_write |-> (r_state == S_XFER));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter. Two instances
//            (RD_LAT = 1 and RD_LAT = 3), each with its own RAM model,
//            transaction-level reference model, directed scenarios and a
//            randomized requester phase.
// Revision : 1.0 - initial release
// =============================================================================
module tb_mem_port_arbiter;

    logic clk;
    int   checks;
    int   errors;

    initial begin
        clk    = 1'b0;
        checks = 0;
        errors = 0;
    end
    always #5 clk = ~clk;

    task automatic chk(input int lat, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lat%0d %s: got %0h expected %0h at %0t", lat, nm, act, exp, $time);
        end
    endtask

    // Power-up RAM contents, shared by the RAM model and the reference model.
    function automatic logic [15:0] init_word(input int a);
        if (a == 8'h05) return 16'h1234;
        if (a == 8'h2A) return 16'h00FF;
        return 16'(a * 257) ^ 16'h5A5A;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : 3;

        logic        reset;
        logic [2:0]  req;
        logic [2:0]  we;
        logic [23:0] addr;
        logic [47:0] wdata;
        logic [2:0]  ack;
        logic [15:0] rdata;
        logic [7:0]  mem_addr;
        logic [15:0] mem_wdata;
        logic        mem_write;
        logic [15:0] mem_rdata;
        logic        busy;
        logic        done;

        mem_port_arbiter #(.AW(8), .DW(16), .RD_LAT(LAT)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req       (req),
            .we        (we),
            .addr      (addr),
            .wdata     (wdata),
            .ack       (ack),
            .rdata     (rdata),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_write (mem_write),
            .mem_rdata (mem_rdata),
            .busy      (busy)
        );

        // RAM model: synchronous write, read data appears LAT cycles after
        // the address is presented.
        logic [15:0] ram  [0:255];
        logic [15:0] pipe [0:3];
        logic        ram_init = 1'b0;
        always @(posedge clk) begin
            if (!ram_init) begin
                for (int k = 0; k < 256; k++) ram[k] <= init_word(k);
                ram_init <= 1'b1;
            end else if (mem_write) begin
                ram[mem_addr] <= mem_wdata;
            end
            pipe[0] <= ram[mem_addr];
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata = pipe[LAT-1];

        // Reference model: transaction schedule in absolute cycle numbers.
        logic [15:0] mmem [0:255];
        bit          m_init = 0;
        bit          m_valid = 0;
        bit          m_act = 0;
        bit          m_we = 0;
        int          cyc = 0;
        int          m_owner = 0;
        int          m_last = 2;
        int          m_xfer = 0;
        int          m_ackc = 0;
        logic [7:0]  m_maddr = 0;
        logic [15:0] m_mwdata = 0;
        logic [15:0] m_rdata = 0;
        logic [2:0]  e_ack;

        always @(posedge clk) begin
            int o;
            cyc++;
            if (!m_init) begin
                for (int k = 0; k < 256; k++) mmem[k] = init_word(k);
                m_init = 1;
            end
            if (reset) begin
                m_valid  = 1;
                m_act    = 0;
                m_last   = 2;
                m_maddr  = 0;
                m_mwdata = 0;
                m_rdata  = 0;
            end else if (m_valid) begin
                if (!m_act) begin
                    o = -1;
                    for (int k = 1; k <= 3; k++)
                        if (o < 0 && req[(m_last + k) % 3]) o = (m_last + k) % 3;
                    if (o >= 0) begin
                        m_act    = 1;
                        m_owner  = o;
                        m_last   = o;
                        m_we     = we[o];
                        m_maddr  = addr[o*8 +: 8];
                        m_mwdata = wdata[o*16 +: 16];
                        m_xfer   = cyc;
                        m_ackc   = m_we ? cyc + 1 : cyc + 1 + LAT;
                        if (m_we) mmem[m_maddr] = m_mwdata;
                    end
                end else if (cyc > m_ackc) begin
                    m_act = 0;
                end
                if (m_act && !m_we && cyc == m_ackc) m_rdata = mmem[m_maddr];
            end
        end

        // Compare DUT against the model every cycle, mid-cycle.
        always @(negedge clk) begin
            if (m_valid) begin
                e_ack = (m_act && cyc == m_ackc) ? 3'(1 << m_owner) : 3'b000;
                chk(LAT, "ack", ack, e_ack);
                chk(LAT, "busy", busy, m_act);
                chk(LAT, "mem_write", mem_write, m_act && m_we && cyc == m_xfer);
                chk(LAT, "rdata", rdata, m_rdata);
                if (m_act) begin
                    chk(LAT, "mem_addr", mem_addr, m_maddr);
                    chk(LAT, "mem_wdata", mem_wdata, m_mwdata);
                end
            end
        end

        // Directed scenarios followed by randomized requesters.
        initial begin
            int n;
            int nack;
            bit saw_mw;
            reset = 1'b1; req = 0; we = 0; addr = 0; wdata = 0; done = 1'b0;
            repeat (3) @(negedge clk);
            chk(LAT, "reset_busy", busy, 0);
            chk(LAT, "reset_ack", ack, 0);
            reset = 1'b0;

            // Write by requester 1 (cycle 0 is this cycle).
            req = 3'b010; we = 3'b010; addr[8 +: 8] = 8'h10; wdata[16 +: 16] = 16'hBEEF;
            @(negedge clk);
            chk(LAT, "wr_c1_mw", mem_write, 1);
            chk(LAT, "wr_c1_addr", mem_addr, 8'h10);
            chk(LAT, "wr_c1_wdata", mem_wdata, 16'hBEEF);
            chk(LAT, "wr_c1_busy", busy, 1);
            chk(LAT, "wr_c1_ack", ack, 0);
            @(negedge clk);
            chk(LAT, "wr_c2_ack", ack, 3'b010);
            chk(LAT, "wr_c2_mw", mem_write, 0);
            chk(LAT, "wr_c2_busy", busy, 1);
            req = 0; we = 0;
            @(negedge clk);
            chk(LAT, "wr_c3_ack", ack, 0);
            chk(LAT, "wr_c3_busy", busy, 0);

            // Read by requester 0 from 0x05.
            req = 3'b001; addr[0 +: 8] = 8'h05;
            n = 0; saw_mw = 0;
            do begin @(negedge clk); n++; saw_mw |= mem_write; end while (ack == 0 && n < 20);
            chk(LAT, "rd05_lat", n, 2 + LAT);
            chk(LAT, "rd05_ack", ack, 3'b001);
            chk(LAT, "rd05_data", rdata, 16'h1234);
            chk(LAT, "rd05_no_write", saw_mw, 0);
            req = 0;
            @(negedge clk);

            // Read by requester 2 from 0x2A.
            req = 3'b100; we = 0; addr[16 +: 8] = 8'h2A;
            n = 0;
            do begin @(negedge clk); n++; end while (ack == 0 && n < 20);
            chk(LAT, "rd2a_lat", n, 2 + LAT);
            chk(LAT, "rd2a_ack", ack, 3'b100);
            chk(LAT, "rd2a_data", rdata, 16'h00FF);
            req = 0;
            @(negedge clk);

            // Write by requester 0 to 0x2A must not disturb rdata.
            req = 3'b001; we = 3'b001; addr[0 +: 8] = 8'h2A; wdata[0 +: 16] = 16'hAAAA;
            n = 0;
            do begin @(negedge clk); n++; end while (ack == 0 && n < 20);
            chk(LAT, "wr2a_lat", n, 2);
            chk(LAT, "wr2a_rdata_held", rdata, 16'h00FF);
            req = 0; we = 0;
            @(negedge clk);

            // Read back 0x2A by requester 1.
            req = 3'b010; addr[8 +: 8] = 8'h2A;
            n = 0;
            do begin @(negedge clk); n++; end while (ack == 0 && n < 20);
            chk(LAT, "rb2a_ack", ack, 3'b010);
            chk(LAT, "rb2a_data", rdata, 16'hAAAA);
            req = 0;
            @(negedge clk);

            // Fairness: all three write continuously after reset.
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            req = 3'b111; we = 3'b111; addr = 24'h323130; wdata = 48'hC002_C001_C000;
            nack = 0;
            for (int c = 1; c <= 40 && nack < 6; c++) begin
                @(negedge clk);
                if (ack != 0) begin
                    chk(LAT, "rr_order", ack, 3'b001 << (nack % 3));
                    chk(LAT, "rr_cycle", c, 2 + 3 * nack);
                    nack++;
                    if (nack == 6) begin req = 0; we = 0; end
                end
            end
            chk(LAT, "rr_count", nack, 6);
            @(negedge clk);

            // Reset during XFER of a requester 2 write.
            req = 3'b100; we = 3'b100; addr[16 +: 8] = 8'h40; wdata[32 +: 16] = 16'h1111;
            @(negedge clk);
            chk(LAT, "rst_xfer_mw", mem_write, 1);
            reset = 1'b1; req = 3'b101; we = 3'b101; addr[0 +: 8] = 8'h41; wdata[0 +: 16] = 16'h2222;
            @(negedge clk);
            chk(LAT, "rst_mw", mem_write, 0);
            chk(LAT, "rst_busy", busy, 0);
            chk(LAT, "rst_ack", ack, 0);
            chk(LAT, "rst_addr", mem_addr, 0);
            reset = 1'b0;
            @(negedge clk);
            chk(LAT, "rst_next_addr", mem_addr, 8'h41);
            chk(LAT, "rst_next_mw", mem_write, 1);
            @(negedge clk);
            chk(LAT, "rst_next_ack", ack, 3'b001);
            req = 0; we = 0;
            @(negedge clk);

            // Requester 1 read of the aborted write's address, req dropped in XFER.
            req = 3'b010; we = 0; addr[8 +: 8] = 8'h40;
            @(negedge clk);
            chk(LAT, "drop_xfer_busy", busy, 1);
            req = 3'b001; we = 3'b001; addr[0 +: 8] = 8'h50; wdata[0 +: 16] = 16'h3333;
            n = 1;
            do begin @(negedge clk); n++; end while (ack == 0 && n < 20);
            chk(LAT, "drop_ack", ack, 3'b010);
            chk(LAT, "drop_lat", n, 2 + LAT);
            chk(LAT, "drop_rdata", rdata, 16'h1111);
            @(negedge clk);
            chk(LAT, "drop_idle", busy, 0);
            @(negedge clk);
            chk(LAT, "drop_next_addr", mem_addr, 8'h50);
            chk(LAT, "drop_next_mw", mem_write, 1);
            @(negedge clk);
            chk(LAT, "drop_next_ack", ack, 3'b001);
            req = 0; we = 0;
            @(negedge clk);

            // Randomized requesters with occasional reset.
            for (int c = 0; c < 800; c++) begin
                @(negedge clk);
                if (reset) reset = 1'b0;
                else if ($urandom_range(99) == 0) reset = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    if (req[i]) begin
                        if (ack[i]) begin
                            if ($urandom_range(1) == 0) begin
                                req[i] = 1'b0;
                            end else begin
                                we[i] = 1'($urandom_range(1));
                                addr[i*8 +: 8] = 8'($urandom_range(31));
                                wdata[i*16 +: 16] = 16'($urandom);
                            end
                        end else if ($urandom_range(49) == 0) begin
                            req[i] = 1'b0;
                        end
                    end else if ($urandom_range(3) == 0) begin
                        req[i] = 1'b1;
                        we[i] = 1'($urandom_range(1));
                        addr[i*8 +: 8] = 8'($urandom_range(31));
                        wdata[i*16 +: 16] = 16'($urandom);
                    end
                end
            end
            req = 0; reset = 1'b0;
            repeat (8) @(negedge clk);
            done = 1'b1;
        end
    end

    initial begin
        fork
            begin
                wait (g_inst[0].done && g_inst[1].done);
            end
            begin
                repeat (20000) @(posedge clk);
                checks++;
                errors++;
                $display("FAIL timeout: got not-done expected done at %0t", $time);
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
